// File: rtl/sys_ram_byte_packer.sv
// Packs a byte stream little-endian into 32-bit words and writes them to the
// system RAM over a zero-wait-state Avalon-MM port, one command at a time.
module sys_ram_byte_packer #(
  parameter int ADDR_W = 15,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic [ADDR_W-1:0] ram_address,
  output logic [3:0]        ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [31:0]       ram_writedata,
  output logic              ram_clken,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [LEN_W-1:0]  remaining_reg;
  logic [1:0]        lane_reg;
  logic              cmd_ready_reg;
  logic              in_ready_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              write_reg;

  logic              cmd_take;
  logic              byte_take;
  logic              word_last;
  logic              lane_clear;
  logic [3:0][7:0]   lane_data;
  logic [3:0]        lane_be;

  assign cmd_take   = (state_reg == IDLE) && cmd_valid;
  assign byte_take  = (state_reg == FILL) && in_valid;
  assign word_last  = (lane_reg == 2'd3) || (remaining_reg == LEN_W'(1));
  // A new command and the cycle after a write both start an empty word.
  assign lane_clear = cmd_take || (state_reg == WRITE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          state_next = (cmd_len == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (in_valid && word_last) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        state_next = (remaining_reg == '0) ? DONE : FILL;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control registers and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      lane_reg      <= '0;
      cmd_ready_reg <= 1'b0;
      in_ready_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      write_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (cmd_take) begin
        addr_reg      <= cmd_addr;
        remaining_reg <= cmd_len;
        lane_reg      <= '0;
      end else if (byte_take) begin
        remaining_reg <= remaining_reg - LEN_W'(1);
        lane_reg      <= lane_reg + 2'd1;
      end else if (state_reg == WRITE) begin
        addr_reg <= addr_reg + ADDR_W'(1);
        lane_reg <= '0;
      end
      cmd_ready_reg <= (state_next == IDLE);
      in_ready_reg  <= (state_next == FILL);
      busy_reg      <= (state_next != IDLE);
      done_reg      <= (state_next == DONE);
      write_reg     <= (state_next == WRITE);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] byte_reg;
      logic       be_reg;
      logic       lane_hit;

      assign lane_hit = byte_take && (lane_reg == 2'(gi));

      always_ff @(posedge clk) begin
        if (reset) begin
          byte_reg <= '0;
          be_reg   <= 1'b0;
        end else if (lane_clear) begin
          byte_reg <= '0;
          be_reg   <= 1'b0;
        end else if (lane_hit) begin
          byte_reg <= in_data;
          be_reg   <= 1'b1;
        end
      end

      assign lane_data[gi] = byte_reg;
      assign lane_be[gi]   = be_reg;
    end
  endgenerate

  assign cmd_ready      = cmd_ready_reg;
  assign in_ready       = in_ready_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;
  assign ram_address    = addr_reg;
  assign ram_writedata  = lane_data;
  assign ram_byteenable = lane_be;
  assign ram_chipselect = write_reg;
  assign ram_write      = write_reg;
  assign ram_clken      = 1'b1;

endmodule

// File: tb/tb_sys_ram_byte_packer.sv
// Bench for sys_ram_byte_packer: table of commands checked against a packing
// model via a write scoreboard, plus hand-written reset sequences.
module tb_sys_ram_byte_packer;

  localparam int ADDR_W = 15;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic [ADDR_W-1:0] ram_address;
  logic [3:0]        ram_byteenable;
  logic              ram_chipselect;
  logic              ram_write;
  logic [31:0]       ram_writedata;
  logic              ram_clken;
  logic              busy;
  logic              done;

  sys_ram_byte_packer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .ram_address    (ram_address),
    .ram_byteenable (ram_byteenable),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_writedata  (ram_writedata),
    .ram_clken      (ram_clken),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [7:0]        first;
    logic [7:0]        step;
    bit                stall;
    bit                hold;
    int                exp_writes;
    logic [3:0]        exp_last_be;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        be;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  int         n_vec = 0;
  int         n_bad = 0;
  int         writes_seen = 0;
  int         done_seen = 0;
  int         cyc = 0;
  logic [3:0] last_be_seen = '0;
  int         pat[8] = '{1, 0, 0, 1, 1, 0, 1, 1};
  vec_t       vecs[8];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // Write monitor: every RAM write is matched against the scoreboard.
  always @(negedge clk) begin
    if (ram_write) begin
      check("write_chipselect", ram_chipselect, 1);
      check("write_in_ready", in_ready, 0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h be 0x%0h, expected no write",
                 ram_address, ram_writedata, ram_byteenable);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", ram_address, mon_e.addr);
        check("write_data", ram_writedata, mon_e.data);
        check("write_be", ram_byteenable, mon_e.be);
        $display("write addr=0x%04h data=0x%08h be=0x%0h", ram_address, ram_writedata, ram_byteenable);
      end
      last_be_seen = ram_byteenable;
      writes_seen++;
    end
    if (busy) check("cmd_ready_while_busy", cmd_ready, 0);
    if (done) done_seen++;
  end

  function automatic vec_t mk(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                              input logic [7:0] f, input logic [7:0] s, input bit st,
                              input bit h, input int ew, input logic [3:0] eb);
    vec_t v;
    v.addr = a; v.len = l; v.first = f; v.step = s; v.stall = st; v.hold = h;
    v.exp_writes = ew; v.exp_last_be = eb;
    return v;
  endfunction

  // Called on a negedge; returns on a negedge.
  task automatic run_cmd(input vec_t v);
    int         t;
    int         idx;
    int         step;
    int         acc;
    int         w0;
    int         d0;
    int         exp_lat;
    logic       take;
    logic [31:0] d;
    logic [3:0]  b;
    wr_t         e;
    d = '0;
    b = '0;
    for (int i = 0; i < int'(v.len); i++) begin
      d[8*(i%4) +: 8] = v.first + 8'(i * int'(v.step));
      b[i%4] = 1'b1;
      if ((i % 4 == 3) || (i == int'(v.len) - 1)) begin
        e.addr = v.addr + ADDR_W'(i / 4);
        e.data = d;
        e.be   = b;
        exp_q.push_back(e);
        d = '0;
        b = '0;
      end
    end
    w0 = writes_seen;
    d0 = done_seen;
    cmd_addr  = v.addr;
    cmd_len   = v.len;
    cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      timeout("cmd_accept");
      cmd_valid = 1'b0;
      return;
    end
    acc = cyc;
    @(negedge clk);
    if (!v.hold) cmd_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    idx = 0;
    step = 0;
    t = 0;
    while (idx < int'(v.len) && t < 1000) begin
      in_valid = v.stall ? (pat[step % 8] != 0) : 1'b1;
      in_data  = v.first + 8'(idx * int'(v.step));
      take     = in_valid && in_ready;
      @(negedge clk);
      if (take) idx++;
      step++;
      t++;
    end
    in_valid = 1'b0;
    if (idx < int'(v.len)) timeout("stream_bytes");
    t = 0;
    while (!done && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("done_pulse", done, 1);
    exp_lat = (v.len == 0) ? 1 : int'(v.len) + (int'(v.len) + 3) / 4 + 1;
    if (!v.stall) check("latency", cyc - acc, exp_lat);
    @(negedge clk);
    check("done_width", done, 0);
    check("write_count", writes_seen - w0, v.exp_writes);
    if (v.exp_writes > 0) check("last_be", last_be_seen, v.exp_last_be);
    check("done_count", done_seen - d0, 1);
    check("queue_empty", exp_q.size(), 0);
    $display("cmd addr=0x%04h len=%0d stall=%0d writes=%0d latency=%0d",
             v.addr, v.len, v.stall, writes_seen - w0, cyc - acc - 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int taken;
    int w0;
    int d0;
    logic take;

    vecs[0] = mk(15'h0010, 16'd4,  8'h11, 8'h11, 1'b0, 1'b0, 1, 4'hF);
    vecs[1] = mk(15'h0100, 16'd6,  8'hA0, 8'h01, 1'b0, 1'b0, 2, 4'h3);
    vecs[2] = mk(15'h0200, 16'd0,  8'h00, 8'h00, 1'b0, 1'b0, 0, 4'h0);
    vecs[3] = mk(15'h7FFF, 16'd8,  8'h10, 8'h03, 1'b0, 1'b1, 2, 4'hF);
    vecs[4] = mk(15'h0300, 16'd5,  8'h5A, 8'h07, 1'b1, 1'b0, 2, 4'h1);
    vecs[5] = mk(15'h0300, 16'd5,  8'h5A, 8'h07, 1'b0, 1'b0, 2, 4'h1);
    vecs[6] = mk(15'h0400, 16'd3,  8'hC1, 8'h22, 1'b0, 1'b0, 1, 4'h7);
    vecs[7] = mk(15'h0500, 16'd13, 8'hF0, 8'h0D, 1'b0, 1'b0, 4, 4'h1);

    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(negedge clk);
    check("rst_ram_write", ram_write, 0);
    check("rst_chipselect", ram_chipselect, 0);
    check("rst_byteenable", ram_byteenable, 0);
    check("rst_writedata", ram_writedata, 0);
    check("rst_address", ram_address, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("clken", ram_clken, 1);
    reset = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_reset", cmd_ready, 1);

    for (int i = 0; i < 8; i++) run_cmd(vecs[i]);

    // Reset after two bytes of a four-byte command: nothing may be written.
    cmd_addr = 15'h0050;
    cmd_len = 16'd4;
    cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) timeout("rst_mid_accept");
    @(negedge clk);
    cmd_valid = 1'b0;
    taken = 0;
    t = 0;
    while (taken < 2 && t < 50) begin
      in_valid = 1'b1;
      in_data = 8'hE0 + 8'(taken);
      take = in_ready;
      @(negedge clk);
      if (take) taken++;
      t++;
    end
    in_valid = 1'b0;
    if (taken < 2) timeout("rst_mid_bytes");
    w0 = writes_seen;
    d0 = done_seen;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_byteenable", ram_byteenable, 0);
    check("midrst_writedata", ram_writedata, 0);
    check("midrst_address", ram_address, 0);
    @(negedge clk);
    check("midrst_cmd_ready", cmd_ready, 1);
    repeat (4) @(negedge clk);
    check("midrst_no_write", writes_seen - w0, 0);
    check("midrst_no_done", done_seen - d0, 0);
    $display("reset mid-transfer after %0d bytes", taken);

    run_cmd(mk(15'h0050, 16'd4, 8'h81, 8'h11, 1'b0, 1'b0, 1, 4'hF));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
